// File: rtl/csa_pkg.sv
// Shared types and elaboration helpers for the carry-save resolver.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } csa_state_e;

  function automatic int unsigned nchunk(input int unsigned n, input int unsigned k);
    return n / k;
  endfunction

  // Chunk counter width; never narrower than one bit, even for a single chunk.
  function automatic int unsigned cnt_width(input int unsigned nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/csa_resolve_chunk_add.sv
// K-bit ripple-carry adder built from per-bit full adders.
module csa_chunk_add #(
  parameter int unsigned K = 2
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         ci,
  output logic [K-1:0] s,
  output logic         co
);

  always_comb begin
    logic carry;
    s     = '0;
    carry = ci;
    for (int unsigned i = 0; i < K; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    co = carry;
  end

endmodule

// File: rtl/csa_resolve.sv
// Sequential carry-propagate resolver: turns a carry-save pair (S, C) into R = S + 2*C, K bits per cycle.
module csa_resolve
  import csa_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned K = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] S,
  input  logic [N-1:0] C,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N+1:0] R
);

  localparam int unsigned NCHUNK = nchunk(N, K);
  localparam int unsigned CW     = cnt_width(NCHUNK);

  if ((K < 1) || (K > N) || ((N % K) != 0)) begin : g_param_check
    $error("csa_resolve: N must be a non-zero multiple of K");
  end

  csa_state_e    state;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          top;
  logic          cy;
  logic [CW-1:0] cnt;

  logic [K-1:0]  a_chunk;
  logic [K-1:0]  b_chunk;
  logic [K-1:0]  sum_chunk;
  logic          co;
  logic          last_chunk;

  // Chunk selection by compare against each constant offset keeps all slices static.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned j = 0; j < NCHUNK; j++) begin
      if (cnt == CW'(j)) begin
        a_chunk = a[j*K +: K];
        b_chunk = b[j*K +: K];
      end
    end
  end

  assign last_chunk = (cnt == CW'(NCHUNK - 1));

  csa_chunk_add #(.K(K)) u_chunk_add (
    .a  (a_chunk),
    .b  (b_chunk),
    .ci (cy),
    .s  (sum_chunk),
    .co (co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      R         <= '0;
      cnt       <= '0;
      cy        <= 1'b0;
      a         <= '0;
      b         <= '0;
      top       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a        <= S;
            // Carry vector shifted into weight-1 alignment; its MSB becomes the top bit.
            b        <= N'({C, 1'b0});
            top      <= C[N-1];
            cy       <= 1'b0;
            cnt      <= '0;
            R        <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          for (int unsigned j = 0; j < NCHUNK; j++) begin
            if (cnt == CW'(j)) R[j*K +: K] <= sum_chunk;
          end
          cy  <= co;
          cnt <= cnt + 1'b1;
          if (last_chunk) begin
            R[N+1:N]  <= {1'b0, top} + {1'b0, co};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/csa_resolve.md
# csa_resolve

Sequential carry-propagate resolver for carry-save results. It accepts one redundant pair (S, C) per transaction, as produced by `nb_csa`, where C carries weight 2 relative to S. It returns the binary value R = S + 2·C by rippling K bits per cycle. It sits between the carry-save reduction tree and any consumer that needs a plain binary word, and uses valid/ready handshakes on both sides.

## Interface
- N, default 4: width of S and C. Must be a multiple of K.
- K, default 2: bits resolved per cycle. 1 ≤ K ≤ N.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  S/C are valid.
- in_ready  out  1  block can accept an input pair.
- S  in  N  carry-save sum vector, weight 1.
- C  in  N  carry-save carry vector, weight 2.
- out_valid  out  1  R holds a completed result.
- out_ready  in  1  consumer accepts R.
- R  out  N+2  binary result, S + 2·C. The maximum is 3·2^N − 3.

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE → BUSY on in_valid & in_ready. On that edge:
  - capture A = S and B = {C[N-2:0], 1'b0};
  - capture top = C[N-1];
  - clear the carry flag, chunk counter cnt and R.
- BUSY does one chunk per cycle at bit offset i = cnt·K:
  - {cy', R[i+K-1:i]} = A[i+K-1:i] + B[i+K-1:i] + cy;
  - cnt increments.
- Last chunk (cnt = N/K−1):
  - also write R[N+1:N] = top + cy' (2-bit);
  - go to DONE.
- DONE → IDLE on out_valid & out_ready.
- While out_valid=1 and out_ready=0, R and the state hold stable.
- Inputs are ignored outside IDLE. S and C need only be stable on the accept edge.
- Arithmetic is exact. There is no overflow or truncation, because R is N+2 bits.
- N=1 corner: B = 0 and top = C[0].

## Timing
- Reset (asynchronous assert, any state) gives:
  - state=IDLE, in_ready=1, out_valid=0, R=0, cnt=0, cy=0.
- Reset mid-BUSY or mid-DONE abandons the transaction. No output is produced.
- Latency: accept edge at cycle t, then out_valid=1 from cycle t+N/K.
  - For N=4, K=2: 2 cycles.
  - For K=N: 1 cycle.
- The output handshake edge returns to IDLE. in_ready=1 on the next cycle.
- Input is not accepted in the same cycle as the output handshake. Back-to-back throughput is one result per N/K+2 cycles.
- Intermediate R bits are not meaningful while out_valid=0.

## Structure
- Shared package `csa_pkg`:
  - state encoding constants IDLE/BUSY/DONE (2-bit);
  - NCHUNK = N/K;
  - counter width CW = max(1, clog2(NCHUNK)).
- Sub-module `csa_chunk_add`:
  - K-bit ripple adder with ports a, b, ci, s, co;
  - built from per-bit full adders (s = a^b^ci, co = majority(a,b,ci));
  - instantiated once in the datapath.
- Elaboration-time check: N % K == 0. Otherwise `$error`.

## Test plan
- Reset and idle (N=8, K=2): hold rst_n=0, release.
  - Required: in_ready=1, out_valid=0, R=0. No activity with in_valid=0.
- Basic values (N=8, K=2):
  - S=0xFF, C=0xFF → R=0x2FD after 4 cycles.
  - S=0x5A, C=0x0F → R=0x078.
  - S=0, C=0 → R=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises.
  - Required: R is constant, in_ready stays 0, and in_valid pulses are ignored.
  - Releasing out_ready gives exactly one handshake.
- Reset mid-operation: assert rst_n=0 one cycle after accept.
  - Required: immediate in_ready=1, out_valid=0, R=0.
  - No stale result appears after release.
- Parameter sweep (K=1, K=N for N=4 and N=8):
  - Exhaustive for N=4: all 256 (S,C) pairs match S+2C.
  - Latency equals N/K.
- End-to-end: random X, Y, Z feed `nb_csa` and its S/Cout feed this block.
  - Required: R = X+Y+Z for 1000 random vectors, with random out_ready throttling.
